// File: rtl/pulse_divider_multi.sv
// rtl/pulse_divider_multi.sv - multi-channel laser pulse divider with row-pack lockout
module pulse_divider_multi #(
  parameter int WIDTH     = 16,
  parameter int ROW_WIDTH = 16,
  parameter int CHANNELS  = 2
) (
  input  logic                laser_pulse,
  input  logic                sr_reset,
  input  logic                sr_data,
  input  logic                sr_shift,
  input  logic                sr_latch,
  input  logic [CHANNELS-1:0] divide_enable,
  input  logic                constant_v,
  input  logic                en_rowpack,
  input  logic                row_rearm,
  output logic [CHANNELS-1:0] divided_pulse,
  output logic [CHANNELS-1:0] row_completed
);

  // Per-channel field is {mode, row_len, divider}; channel 0 sits at the LSB end.
  localparam int FIELD = 1 + ROW_WIDTH + WIDTH;
  localparam int L     = CHANNELS * FIELD;

  logic [L-1:0]        chain;
  logic [CHANNELS-1:0] state;
  logic [CHANNELS-1:0] done;

  // Serial configuration chain, shifted MSB-first; reset fills it with ones.
  always_ff @(posedge laser_pulse or posedge sr_reset) begin
    if (sr_reset) begin
      chain <= '1;
    end else if (sr_shift) begin
      chain <= {chain[L-2:0], sr_data};
    end
  end

  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_ch
      logic [WIDTH-1:0]     cfg_div;
      logic [ROW_WIDTH-1:0] cfg_row;
      logic                 cfg_mode;
      logic [WIDTH-1:0]     cnt;
      logic [ROW_WIDTH-1:0] row_cnt;
      logic                 st;
      logic                 row_done;

      logic                 off;
      logic                 tick;
      logic                 want;
      logic                 row_active;
      logic                 locked;
      logic                 nxt;
      logic                 rise;
      logic [ROW_WIDTH-1:0] row_base;
      logic [ROW_WIDTH-1:0] row_inc;
      logic                 count_it;

      // Next-state decode: tick detection, mode shaping, lockout and row accounting.
      always_comb begin
        off  = (cfg_div == '0) || !divide_enable[g];
        tick = !off && (cnt == cfg_div - WIDTH'(1));
        if (off) begin
          want = 1'b0;
        end else if (cfg_mode) begin
          want = tick;
        end else begin
          want = tick ? ~st : st;
        end
        row_active = en_rowpack && (cfg_row != '0);
        // A rearm on this edge releases the lock before the rise is judged.
        locked   = row_active && row_done && !row_rearm;
        // While locked the output may fall but any 0->1 transition is squashed.
        nxt      = want && !(locked && !st);
        rise     = nxt && !st;
        row_base = row_rearm ? '0 : row_cnt;
        row_inc  = row_base + ROW_WIDTH'(1);
        count_it = row_active && rise && constant_v && (row_base < cfg_row);
      end

      // Channel registers; a latch commits the new config and restarts phase from zero.
      always_ff @(posedge laser_pulse or posedge sr_reset) begin
        if (sr_reset) begin
          cfg_div  <= '1;
          cfg_row  <= '0;
          cfg_mode <= 1'b0;
          cnt      <= '0;
          st       <= 1'b0;
          row_cnt  <= '0;
          row_done <= 1'b0;
        end else if (sr_latch) begin
          cfg_div  <= chain[g*FIELD +: WIDTH];
          cfg_row  <= chain[g*FIELD+WIDTH +: ROW_WIDTH];
          cfg_mode <= chain[g*FIELD+WIDTH+ROW_WIDTH];
          cnt      <= '0;
          st       <= 1'b0;
          row_cnt  <= '0;
          row_done <= 1'b0;
        end else begin
          cnt <= (off || tick) ? '0 : cnt + WIDTH'(1);
          st  <= nxt;
          if (!row_active) begin
            row_cnt  <= '0;
            row_done <= 1'b0;
          end else if (count_it) begin
            row_cnt  <= row_inc;
            row_done <= (row_inc == cfg_row);
          end else begin
            row_cnt  <= row_base;
            row_done <= row_done && !row_rearm;
          end
        end
      end

      assign state[g] = st;
      assign done[g]  = row_done;
    end
  endgenerate

  assign divided_pulse = state & {CHANNELS{constant_v}};
  assign row_completed = done;

endmodule

// File: tb/tb_pulse_divider_multi.sv
// tb/tb_pulse_divider_multi.sv - scoreboard bench for pulse_divider_multi
module tb_pulse_divider_multi;
  localparam int WIDTH     = 16;
  localparam int ROW_WIDTH = 16;
  localparam int CHANNELS  = 2;
  localparam int F         = 1 + ROW_WIDTH + WIDTH;
  localparam int L         = CHANNELS * F;

  logic                laser_pulse = 1'b0;
  logic                sr_reset;
  logic                sr_data;
  logic                sr_shift;
  logic                sr_latch;
  logic [CHANNELS-1:0] divide_enable;
  logic                constant_v;
  logic                en_rowpack;
  logic                row_rearm;
  logic [CHANNELS-1:0] divided_pulse;
  logic [CHANNELS-1:0] row_completed;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_q[$];

  // reference state
  logic [L-1:0] m_chain;
  int           m_div[CHANNELS];
  int           m_row[CHANNELS];
  int           m_mode[CHANNELS];
  int           m_ph[CHANNELS];
  int           m_rc[CHANNELS];
  bit           m_st[CHANNELS];
  bit           m_done[CHANNELS];

  pulse_divider_multi #(.WIDTH(WIDTH), .ROW_WIDTH(ROW_WIDTH), .CHANNELS(CHANNELS)) dut (
    .laser_pulse   (laser_pulse),
    .sr_reset      (sr_reset),
    .sr_data       (sr_data),
    .sr_shift      (sr_shift),
    .sr_latch      (sr_latch),
    .divide_enable (divide_enable),
    .constant_v    (constant_v),
    .en_rowpack    (en_rowpack),
    .row_rearm     (row_rearm),
    .divided_pulse (divided_pulse),
    .row_completed (row_completed)
  );

  always #5 laser_pulse = ~laser_pulse;

  function automatic logic [L-1:0] make_cfg(input int m1, input int r1, input int d1,
                                            input int m0, input int r0, input int d0);
    return {1'(m1), ROW_WIDTH'(r1), WIDTH'(d1), 1'(m0), ROW_WIDTH'(r0), WIDTH'(d0)};
  endfunction

  // Behavioural model of one laser edge using the inputs currently driven.
  task automatic model_edge();
    logic [L-1:0] old_chain;
    bit           tick;
    bit           want;
    bit           locked;
    bit           rise;
    bit           active;
    logic [3:0]   e;
    old_chain = m_chain;
    if (sr_reset) begin
      m_chain = '1;
      for (int i = 0; i < CHANNELS; i++) begin
        m_div[i] = (1 << WIDTH) - 1;
        m_row[i] = 0; m_mode[i] = 0; m_ph[i] = 0;
        m_rc[i] = 0; m_st[i] = 0; m_done[i] = 0;
      end
    end else begin
      if (sr_shift) m_chain = {m_chain[L-2:0], sr_data};
      for (int i = 0; i < CHANNELS; i++) begin
        if (sr_latch) begin
          m_div[i]  = int'(old_chain[i*F +: WIDTH]);
          m_row[i]  = int'(old_chain[i*F+WIDTH +: ROW_WIDTH]);
          m_mode[i] = int'(old_chain[i*F+WIDTH+ROW_WIDTH]);
          m_ph[i] = 0; m_rc[i] = 0; m_st[i] = 0; m_done[i] = 0;
        end else begin
          active = en_rowpack && (m_row[i] != 0);
          locked = active && m_done[i] && !row_rearm;
          if (m_div[i] == 0 || !divide_enable[i]) begin
            m_ph[i] = 0;
            want = 0;
          end else begin
            m_ph[i] = (m_ph[i] + 1) % m_div[i];
            tick = (m_ph[i] == 0);
            if (m_mode[i] == 1) want = tick;
            else want = tick ? !m_st[i] : m_st[i];
          end
          if (locked && want && !m_st[i]) want = 0;
          rise = want && !m_st[i];
          m_st[i] = want;
          if (!active) begin
            m_rc[i] = 0; m_done[i] = 0;
          end else begin
            if (row_rearm) begin m_rc[i] = 0; m_done[i] = 0; end
            if (rise && constant_v && m_rc[i] < m_row[i]) begin
              m_rc[i]++;
              if (m_rc[i] == m_row[i]) m_done[i] = 1;
            end
          end
        end
      end
    end
    for (int i = 0; i < CHANNELS; i++) begin
      e[i]          = m_st[i] & constant_v;
      e[CHANNELS+i] = m_done[i];
    end
    exp_q.push_back(e);
  endtask

  // Called at a negedge with inputs set; the following posedge consumes them.
  task automatic step();
    model_edge();
    @(negedge laser_pulse);
  endtask

  task automatic shift_cfg(input logic [L-1:0] v, input bit latch_first);
    for (int b = L - 1; b >= 0; b--) begin
      sr_data  = v[b];
      sr_shift = 1'b1;
      sr_latch = latch_first && (b == L - 1);
      step();
    end
    sr_shift = 1'b0;
    sr_latch = 1'b0;
    sr_data  = 1'b0;
  endtask

  task automatic latch_cfg();
    sr_latch = 1'b1;
    step();
    sr_latch = 1'b0;
  endtask

  // Monitor: every DUT edge produces an output sample matched against the queue.
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge laser_pulse);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({row_completed, divided_pulse} !== e) begin
          errors++;
          $display("FAIL outputs t=%0t actual rc=%b dp=%b required rc=%b dp=%b",
                   $time, row_completed, divided_pulse, e[3:2], e[1:0]);
        end
      end
    end
  end

  initial begin
    sr_reset = 1'b1; sr_data = 1'b0; sr_shift = 1'b0; sr_latch = 1'b0;
    divide_enable = '0; constant_v = 1'b0; en_rowpack = 1'b0; row_rearm = 1'b0;
    repeat (3) step();
    sr_reset = 1'b0;

    // default config after reset: huge divider, no output within this window
    divide_enable = 2'b01; constant_v = 1'b1;
    repeat (200) step();

    // ch0 D=3 toggle, ch1 D=5 pulse
    divide_enable = 2'b11;
    shift_cfg(make_cfg(1, 0, 5, 0, 0, 3), 0);
    latch_cfg();
    repeat (40) step();

    // row-pack lockout on ch0 D=2 R=4, then rearm
    shift_cfg(make_cfg(0, 0, 0, 0, 4, 2), 0);
    en_rowpack = 1'b1;
    latch_cfg();
    repeat (30) step();
    row_rearm = 1'b1;
    step();
    row_rearm = 1'b0;
    repeat (20) step();

    // gated rises are not counted
    latch_cfg();
    for (int k = 0; k < 40; k++) begin
      constant_v = !(k >= 4 && k < 12);
      step();
    end
    constant_v = 1'b1;

    // latch together with shift commits the pre-shift chain
    shift_cfg(make_cfg(0, 0, 4, 1, 0, 3), 0);
    shift_cfg(make_cfg(1, 3, 7, 0, 2, 1), 1);
    repeat (30) step();

    // asynchronous reset mid-row
    latch_cfg();
    step();
    sr_reset = 1'b1;
    #1;
    checks++;
    if (divided_pulse !== '0 || row_completed !== '0) begin
      errors++;
      $display("FAIL async_reset actual dp=%b rc=%b required dp=00 rc=00", divided_pulse, row_completed);
    end
    repeat (2) step();
    sr_reset = 1'b0;
    repeat (5) step();

    // D=0 and D=1 in both modes
    en_rowpack = 1'b0;
    shift_cfg(make_cfg(1, 0, 1, 0, 0, 0), 0);
    latch_cfg();
    repeat (12) step();
    shift_cfg(make_cfg(0, 0, 1, 1, 0, 0), 0);
    latch_cfg();
    repeat (12) step();

    // randomized configurations and control
    for (int r = 0; r < 6; r++) begin
      shift_cfg(make_cfg($urandom_range(1, 0), $urandom_range(4, 0), $urandom_range(5, 0),
                         $urandom_range(1, 0), $urandom_range(4, 0), $urandom_range(5, 0)), 0);
      en_rowpack = ($urandom_range(3, 0) != 0);
      latch_cfg();
      for (int k = 0; k < 120; k++) begin
        constant_v = ($urandom_range(3, 0) != 0);
        row_rearm  = ($urandom_range(19, 0) == 0);
        if ($urandom_range(31, 0) == 0) divide_enable[0] = ~divide_enable[0];
        if ($urandom_range(31, 0) == 0) divide_enable[1] = ~divide_enable[1];
        if ($urandom_range(63, 0) == 0) en_rowpack = ~en_rowpack;
        step();
      end
      row_rearm = 1'b0;
      divide_enable = 2'b11;
    end

    @(posedge laser_pulse);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual pending=%0d required pending=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pulse_divider_multi.md
# pulse_divider_multi

Parametrised, multi-channel successor to the single-channel laser pulse divider. Each channel divides the laser pulse train by its own ratio, in toggle or single-pulse mode, and gates its output with the constant-velocity signal. Each channel counts output pulses per row and locks at a per-channel row length until rearmed. Configuration is shifted in serially and committed atomically to all channels, which restart phase-aligned on commit.

## Interface
- `WIDTH`, 16, divider counter width
- `ROW_WIDTH`, 16, row-length counter width
- `CHANNELS`, 2, number of independent divider channels
- `laser_pulse`  in  1  clock; every rising edge is one laser pulse
- `sr_reset`  in  1  asynchronous, active-high reset
- `sr_data`  in  1  serial configuration data, sampled on `laser_pulse`
- `sr_shift`  in  1  shift `sr_data` into the configuration chain this edge
- `sr_latch`  in  1  commit the chain to the active configuration
- `divide_enable`  in  CHANNELS  per-channel output enable
- `constant_v`  in  1  constant-velocity gate, common to all channels
- `en_rowpack`  in  1  enable row-packing lockout
- `row_rearm`  in  1  clear row counts and release locks on all channels
- `divided_pulse`  out  CHANNELS  gated divided outputs
- `row_completed`  out  CHANNELS  row full; channel locked

## Operation
- Chain length L = CHANNELS*(1+ROW_WIDTH+WIDTH).
  - Layout, MSB to LSB: channel CHANNELS-1 down to channel 0.
  - Each channel field is {mode, row_len, divider}.
  - `sr_shift`=1 sets chain <= {chain[L-2:0], sr_data}, so the data is shifted MSB-first.
- `sr_latch`=1 copies the pre-edge chain to the active configuration.
  - The same edge clears all divide counters, output states, row counts and `row_completed`.
  - If `sr_shift` and `sr_latch` are both high, the latch uses the chain value from before this edge's shift.
- Divide counter, per channel, with D = active divider:
  - D=0: channel off. Counter holds 0 and state is 0.
  - `divide_enable`[i]=0: counter is cleared to 0 and state is cleared to 0.
  - Otherwise the counter increments each edge.
  - At count==D-1, a tick occurs: counter <= 0.
- Mode 0 (toggle): state flips on every tick, giving period 2D and 50% duty.
- Mode 1 (pulse): state is 1 for exactly the one cycle following each tick and 0 otherwise.
- `divided_pulse`[i] = state[i] & `constant_v`. This is combinational after the state flop.
- The counter runs regardless of `constant_v`.
- Row counting, per channel, with R = active row_len. It is active only when `en_rowpack`=1 and R≠0.
  - A "rise" is an edge where state goes 0→1.
  - The row count increments on a rise while `constant_v`=1.
  - When the increment makes count==R, `row_completed`[i] <= 1 on that same edge.
  - The R-th pulse is still emitted.
- While `row_completed`[i]=1:
  - state may fall but never rise. Rises are suppressed; in toggle mode the following tick forces state to 0.
  - The divide counter keeps running.
- `row_rearm`=1 clears all row counts and `row_completed` bits.
  - If a rise occurs on the same edge, it is counted after the clear, so count=1.
- `en_rowpack`=0 holds row counts at 0, `row_completed` at 0, and no lock.
- Priority, highest first: `sr_reset` > `sr_latch` > `row_rearm` > normal operation.
- Counters wrap only via tick or clear. The row count never exceeds R.

## Timing
- `sr_reset` asserts asynchronously and forces:
  - chain = all ones;
  - active divider = 2^WIDTH-1, row_len = 0, mode = 0 on every channel;
  - all counters 0, all states 0, `divided_pulse`=0, `row_completed`=0.
- Reset deassertion must be synchronised externally to `laser_pulse`.
- With `divide_enable` high from edge 1, ticks occur at edges D, 2D, 3D, and so on.
- State changes on the tick edge. `divided_pulse` follows with zero further latency (combinational gate).
- Configuration commit takes effect on the `sr_latch` edge. The first tick under the new config is D edges later.
- `row_completed` rises on the same edge as the R-th counted rise.
- `row_rearm` takes effect on its edge. A rise is possible on the next tick.

## Test plan
- Reset, no config, channel 0 enabled, `constant_v`=1 → toggle period 2×65535 edges; `row_completed`=0.
- Shift in divider=3, mode 0, R=0 on ch0 and divider=5, mode 1 on ch1, then latch → ch0 toggles every 3 edges (period 6); ch1 is high 1 cycle in every 5; both restart aligned to the latch edge.
- Ch0 divider=2, R=4, `en_rowpack`=1 → exactly 4 high pulses; `row_completed`[0] rises with the 4th rise; output stays 0 afterwards; `row_rearm` → pulses resume, count=1 on the first new rise.
- `constant_v` toggled low over 2 of ch0's rises with R=4 → those rises are not counted and outputs are masked; the lock occurs after 4 gated rises.
- `sr_latch` and `sr_shift` on the same edge → the pre-shift chain is committed (check with a known pattern); `sr_reset` asserted mid-row → all outputs 0 immediately without a clock edge.
- Divider=0 and divider=1 in both modes → D=0 gives constant 0; D=1 toggle alternates every edge; D=1 pulse gives constant 1 after the first tick.
